// File: rtl/nqueens_sequencer.sv
// Run controller for the N Queens node chain: starts the search, captures each solution
// by rotating the scan ring, resumes with a backtrack, and exposes results on the global bus.
`ifndef GlobalAddrWidth
`define GlobalAddrWidth 8
`endif
`ifndef GlobalDataWidth
`define GlobalDataWidth 16
`endif
`ifndef GlobalDataHighZ
`define GlobalDataHighZ {`GlobalDataWidth{1'bz}}
`endif

module nqueens_sequencer #(
    parameter int         N        = 8,
    parameter int         IDWIDTH  = 4,
    parameter int         CNTWIDTH = 16,
    parameter logic [7:0] BASE     = 8'h40
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        RD,
    input  logic                        WR,
    input  logic [`GlobalAddrWidth-1:0] Addr,
    input  logic [`GlobalDataWidth-1:0] DataIn,
    output wire  [`GlobalDataWidth-1:0] DataOut,
    output logic                        TopCallOut,
    input  logic                        TopReturnIn,
    input  logic                        BotCallIn,
    output logic                        BotReturnOut,
    output logic                        ScanEnable,
    input  logic [IDWIDTH-1:0]          ScanIn,
    output logic [IDWIDTH-1:0]          ScanOut
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_SEARCH  = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESUME  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                      state;
    logic [CNTWIDTH-1:0]         limit;
    logic [CNTWIDTH-1:0]         sol_count;
    logic [CNTWIDTH-1:0]         cycles;
    logic                        overflow;
    logic [3:0]                  shift_cnt;
    logic [IDWIDTH-1:0]          sol [N];

    logic [7:0]                  offset;
    logic                        hit;
    logic                        ctrl_wr;
    logic                        limit_wr;
    logic [`GlobalDataWidth-1:0] rdata;

    assign offset   = Addr[7:0] - BASE;
    assign ctrl_wr  = WR && (offset == 8'd0);
    assign limit_wr = WR && (offset == 8'd1);

    always_comb begin
        hit   = 1'b1;
        rdata = '0;
        case (offset)
            8'd0:    rdata = `GlobalDataWidth'({overflow, state});
            8'd1:    rdata = `GlobalDataWidth'(limit);
            8'd2:    rdata = `GlobalDataWidth'(sol_count);
            8'd3:    rdata = `GlobalDataWidth'(cycles);
            default: begin
                hit = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (offset == 8'(16 + i)) begin
                        hit   = 1'b1;
                        rdata = `GlobalDataWidth'(sol[i]);
                    end
                end
            end
        endcase
    end

    assign DataOut = (RD && hit) ? rdata : `GlobalDataHighZ;

    // The ring is closed combinationally only while shifting.
    assign ScanOut = ScanEnable ? ScanIn : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= S_IDLE;
            TopCallOut   <= 1'b0;
            BotReturnOut <= 1'b0;
            ScanEnable   <= 1'b0;
            limit        <= '0;
            sol_count    <= '0;
            cycles       <= '0;
            overflow     <= 1'b0;
            shift_cnt    <= '0;
            for (int i = 0; i < N; i++) sol[i] <= '0;
        end else begin
            TopCallOut   <= 1'b0;
            BotReturnOut <= 1'b0;
            if (limit_wr) limit <= DataIn[CNTWIDTH-1:0];
            if ((state inside {S_START, S_SEARCH, S_CAPTURE, S_RESUME}) && (cycles != '1))
                cycles <= cycles + CNTWIDTH'(1);
            case (state)
                S_IDLE, S_DONE: begin
                    if (ctrl_wr) begin
                        sol_count  <= '0;
                        cycles     <= '0;
                        overflow   <= 1'b0;
                        TopCallOut <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: state <= S_SEARCH;
                S_SEARCH: begin
                    if (BotCallIn) begin
                        if (sol_count == '1) overflow <= 1'b1;
                        else                 sol_count <= sol_count + CNTWIDTH'(1);
                        shift_cnt  <= '0;
                        ScanEnable <= 1'b1;
                        state      <= S_CAPTURE;
                    end else if (TopReturnIn) begin
                        state <= S_DONE;
                    end
                end
                S_CAPTURE: begin
                    // Bottom row arrives first, so shift k fills row N-1-k.
                    for (int i = 0; i < N; i++)
                        if (4'(N - 1 - i) == shift_cnt) sol[i] <= ScanIn;
                    shift_cnt <= shift_cnt + 4'd1;
                    if (shift_cnt == 4'(N - 1)) begin
                        ScanEnable <= 1'b0;
                        if ((limit != '0) && (sol_count == limit)) begin
                            state <= S_DONE;
                        end else begin
                            BotReturnOut <= 1'b1;
                            state        <= S_RESUME;
                        end
                    end
                end
                S_RESUME: state <= S_SEARCH;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/nqueens_sequencer.md
# nqueens_sequencer

Run controller for the N Queens node array. It:
- launches a search at the top node;
- on each solution from the bottom node, rotates the scan chain to capture the board into a readable buffer, then issues a backtrack to the bottom node to resume the search;
- stops when the top node reports exhaustion or a programmed solution limit is reached.

It sits on the global bus beside the node chain. It closes the chain in a ring: bottom node CallOut and scan output come in, top node CallIn and scan input go out.

## Interface
Parameters:
- N, 8: rows (nodes in chain), 1..15.
- IDWIDTH, 4: column code width; all-ones = "no column".
- CNTWIDTH, 16: solution and cycle counter width.
- BASE, 8'h40: bus base address, compared against Addr[7:0].

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high.
- RD, WR  in  1  global bus strobes.
- Addr  in  `GlobalAddrWidth  bus address.
- DataIn  in  `GlobalDataWidth  write data.
- DataOut  out  `GlobalDataWidth  read data. Zero-extended when addressed with RD; `GlobalDataHighZ otherwise.
- TopCallOut  out  1  to node 0 CallIn.
- TopReturnIn  in  1  from node 0 ReturnOut (search exhausted).
- BotCallIn  in  1  from node N-1 CallOut (solution found).
- BotReturnOut  out  1  to node N-1 ReturnIn (backtrack).
- ScanEnable  out  1  to all nodes.
- ScanIn  in  IDWIDTH  from node N-1 ScanOut.
- ScanOut  out  IDWIDTH  to node 0 ScanIn.

## Operation
Register map, at BASE+k:
- CTRL, k=0.
  - Write starts a run; ignored unless state is IDLE or DONE.
  - Read: [2:0] = state code, [3] = count overflow.
- LIMIT, k=1. Read/write, CNTWIDTH bits. 0 = unlimited.
- SOLCOUNT, k=2. Read only.
- CYCLES, k=3. Read only.
- SOL[i], k=16+i, i<N. Read only: captured column of row i for the last solution.

Other addresses are not decoded.

States (codes 0..5):
- IDLE (0).
  - On CTRL write: clear SOLCOUNT, CYCLES and the overflow bit → START.
- START (1).
  - TopCallOut=1 for exactly one cycle → SEARCH.
- SEARCH (2).
  - BotCallIn: SOLCOUNT+1, shift counter=0 → CAPTURE.
  - Else TopReturnIn → DONE.
  - BotCallIn has priority if both are seen.
- CAPTURE (3).
  - ScanEnable=1 for exactly N cycles; ScanOut=ScanIn (combinational ring).
  - On shift cycle k, ScanIn is stored into SOL[N-1-k].
  - After N shifts every node holds its original column. SOL is valid from the cycle after the last shift.
  - Then: LIMIT≠0 and SOLCOUNT==LIMIT → DONE; else → RESUME.
- RESUME (4).
  - BotReturnOut=1 for exactly one cycle → SEARCH.
- DONE (5).
  - Hold all results; CTRL write starts a new run as from IDLE.

Arithmetic:
- SOLCOUNT saturates at all-ones and sets the overflow bit.
- CYCLES increments every cycle in states 1–4 and saturates.
- A solution limit compares the saturated count.

ScanOut outside CAPTURE: 0.

## Timing
- Reset: state IDLE; TopCallOut=BotReturnOut=ScanEnable=0; ScanOut=0; SOLCOUNT=CYCLES=LIMIT=0; SOL[*]=0; overflow=0.
  - Reset mid-run aborts to IDLE in the same edge. No pulse is issued afterwards.
- All control outputs are registered state decodes: TopCallOut, BotReturnOut, ScanEnable.
- Latency:
  - CTRL write at edge t → TopCallOut high during cycle t+1 → SEARCH at t+2.
  - BotCallIn seen at edge s → ScanEnable high in cycles s+1..s+N → BotReturnOut in cycle s+N+1, unless the limit is reached.
- BotCallIn and TopReturnIn are ignored outside SEARCH.
- Bus reads are combinational on Addr/RD; writes take effect at the edge with WR=1.
- CTRL write in states 1–4 has no effect, including on counters.
- LIMIT writes are accepted in any state; the new value applies at the next post-capture compare.

## Test plan
- N=4, LIMIT=0, write CTRL:
  - After the first capture SOL = {1,3,0,2}; after the second SOL = {2,0,3,1}.
  - Then TopReturnIn → DONE, SOLCOUNT=2, status=5.
  - After every capture each node's column reads back unchanged.
- N=8, LIMIT=1: DONE after one capture, SOLCOUNT=1, SOL = {0,4,7,5,2,6,1,3}, no BotReturnOut ever asserted.
- N=8, LIMIT=0: SOLCOUNT=92 at DONE; CYCLES nonzero and frozen in DONE.
- N=6: SOLCOUNT=4. N=1: SOLCOUNT=1, SOL[0]=0.
- CTRL write during SEARCH → no second TopCallOut, count unaffected.
  - Reset asserted during CAPTURE → next cycle status=0, all outputs 0.
- CNTWIDTH=4, N=8, LIMIT=0 → SOLCOUNT=15, overflow=1, run still reaches DONE.
  - Reads of unmapped addresses → DataOut high-Z.
